// File: rtl/div_pkg.sv
// Shared widths, FSM encoding and constants for the sequential 16/8 divider.
package div_pkg;

    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;
    localparam int CNT_W      = 5;
    localparam int PR_W       = DIVISOR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [DIVIDEND_W-1:0] DBZ_QUOTIENT = 16'hFFFF;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, conditionally subtract.
module div_step
    import div_pkg::*;
(
    input  logic [PR_W-1:0]      pr,
    input  logic                 din,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [PR_W-1:0]      pr_next,
    output logic                 q_bit
);

    logic [PR_W:0] shifted_s;
    logic [PR_W:0] diff_s;

    assign shifted_s = {pr, din};
    assign diff_s    = shifted_s - {2'b00, divisor};

    // pr < divisor on entry, so the kept result always fits in PR_W bits
    always_comb begin
        pr_next = shifted_s[PR_W-1:0];
        q_bit   = 1'b0;
        if (shifted_s >= {2'b00, divisor}) begin
            pr_next = diff_s[PR_W-1:0];
            q_bit   = 1'b1;
        end else begin
            pr_next = shifted_s[PR_W-1:0];
            q_bit   = 1'b0;
        end
    end

endmodule

// File: rtl/div_16x8_seq.sv
// Sequential restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Define APPROX_DIV_EN to skip the TRUNC_BITS low quotient bits (saturating remainder).
module div_16x8_seq
    import div_pkg::*;
#(
    parameter int TRUNC_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

`ifdef APPROX_DIV_EN
    localparam int APPROX_ON = 1;
`else
    localparam int APPROX_ON = 0;
`endif
    localparam int EFF_TRUNC = (APPROX_ON != 0) ? TRUNC_BITS : 0;
    localparam logic [CNT_W-1:0] ITER = CNT_W'(DIVIDEND_W - EFF_TRUNC);

    state_t                  state_r, state_nxt_s;
    logic                    in_ready_r, out_valid_r;
    logic [DIVIDEND_W-1:0]   dvd_r;
    logic [DIVISOR_W-1:0]    dvs_r;
    logic [PR_W-1:0]         pr_r, pr_next_s;
    logic [DIVIDEND_W-2:0]   quo_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [DIVIDEND_W-1:0]   quotient_r;
    logic [DIVISOR_W-1:0]    remainder_r;
    logic                    dbz_r;
    logic                    q_bit_s, accept_s, last_s;
    logic [DIVIDEND_W-1:0]   quo_nxt_s, quo_final_s;
    logic [DIVISOR_W-1:0]    rem_final_s;

    div_step u_step (
        .pr      (pr_r),
        .din     (dvd_r[DIVIDEND_W-1]),
        .divisor (dvs_r),
        .pr_next (pr_next_s),
        .q_bit   (q_bit_s)
    );

    assign accept_s    = in_valid && in_ready_r;
    assign last_s      = (cnt_r == CNT_W'(1));
    assign quo_nxt_s   = {quo_r, q_bit_s};
    assign quo_final_s = quo_nxt_s << EFF_TRUNC;

`ifdef APPROX_DIV_EN
    // Skipped dividend bits are still at the top of dvd_r just below the bit being consumed
    logic [DIVISOR_W+DIVIDEND_W-2:0] rem_wide_s;
    assign rem_wide_s = {pr_next_s[DIVISOR_W-1:0], dvd_r[DIVIDEND_W-2:0]} >> (DIVIDEND_W - 1 - EFF_TRUNC);
    assign rem_final_s = (rem_wide_s > (DIVISOR_W+DIVIDEND_W-1)'(255)) ? 8'hFF : rem_wide_s[DIVISOR_W-1:0];
`else
    assign rem_final_s = pr_next_s[DIVISOR_W-1:0];
`endif

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = (divisor == 8'd0) ? DONE : CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            DONE: begin
                if (out_valid_r && out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register with handshake flags registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == IDLE);
            out_valid_r <= (state_nxt_s == DONE);
        end
    end

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_r       <= 16'd0;
            dvs_r       <= 8'd0;
            pr_r        <= 9'd0;
            quo_r       <= 15'd0;
            cnt_r       <= 5'd0;
            quotient_r  <= 16'd0;
            remainder_r <= 8'd0;
            dbz_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        dvd_r <= dividend;
                        dvs_r <= divisor;
                        pr_r  <= 9'd0;
                        quo_r <= 15'd0;
                        cnt_r <= ITER;
                        if (divisor == 8'd0) begin
                            quotient_r  <= DBZ_QUOTIENT;
                            remainder_r <= dividend[DIVISOR_W-1:0];
                            dbz_r       <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    dvd_r <= {dvd_r[DIVIDEND_W-2:0], 1'b0};
                    pr_r  <= pr_next_s;
                    quo_r <= quo_nxt_s[DIVIDEND_W-2:0];
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (last_s) begin
                        quotient_r  <= quo_final_s;
                        remainder_r <= rem_final_s;
                        dbz_r       <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_div_16x8_seq.sv
// Self-checking bench for div_16x8_seq: directed cases plus random operands vs. an arithmetic model.
module tb_div_16x8_seq;

`ifdef APPROX_DIV_EN
    localparam int T = 4;
`else
    localparam int T = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] dividend = 16'd0;
    logic [7:0]  divisor = 8'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;

    div_16x8_seq #(.TRUNC_BITS(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division of the kept dividend bits
    task automatic model(input int a, input int b, output int q, output int r, output int dbz);
        int diff;
        if (b == 0) begin
            q = 16'hFFFF; r = a % 256; dbz = 1;
        end else begin
            q = ((a >> T) / b) << T;
            diff = a - q * b;
            r = (diff > 255) ? 255 : diff;
            dbz = 0;
        end
    endtask

    task automatic run_op(input int a, input int b, input int stall, input bit full);
        int q, r, dbz, lat, n;
        bit overlap, unstable;
        model(a, b, q, r, dbz);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk); n++;
        end
        if (full) check("ready_before_accept", in_ready, 1);
        in_valid = 1'b1; dividend = 16'(a); divisor = 8'(b);
        @(negedge clk);
        in_valid = 1'b0; dividend = 16'($urandom); divisor = 8'($urandom);
        lat = 1; overlap = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready) overlap = 1;
            @(negedge clk); lat++;
        end
        if (in_ready && out_valid) overlap = 1;
        if (full) check("latency", lat, (b == 0) ? 1 : 17 - T);
        if (full) check("ready_low_busy", overlap, 0);
        check("quotient", quotient, q);
        check("remainder", remainder, r);
        check("div_by_zero", div_by_zero, dbz);
        unstable = 0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (!out_valid || in_ready || quotient !== 16'(q) || remainder !== 8'(r)) unstable = 1;
        end
        if (stall > 0) check("stall_hold", unstable, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        if (full) check("after_handshake", {in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        int q, r, dbz;
        bit stray;
        // Reset state
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_outputs", {out_valid, quotient, remainder, div_by_zero}, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        run_op(1000, 7, 0, 1);
        run_op(65535, 1, 0, 1);
        run_op(5, 200, 0, 1);
        run_op(100, 0, 0, 1);
        run_op(40000, 255, 10, 1);
        run_op(4095, 1, 0, 1);

        // Abort mid-calculation by reset
        in_valid = 1'b1; dividend = 16'd1234; divisor = 8'd9;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {out_valid, quotient, remainder, div_by_zero}, 0);
        check("abort_in_ready", in_ready, 1);
        @(negedge clk); rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid || !in_ready) stray = 1;
        end
        check("no_stray_result", stray, 0);
        run_op(1234, 9, 0, 1);

        // Random operands, occasional zero divisor, random back-pressure
        for (int i = 0; i < 60; i++) begin
            int a, b;
            a = int'($urandom_range(0, 65535));
            b = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
            run_op(a, b, int'($urandom_range(0, 3)), (i % 4) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
